// File: rtl/xinj_sched.sv
// Stimulus scheduler for a bank of X-instrumented flops: drives rD/rV from one shared
// LFSR, counts accepted violations, and enforces a campaign budget and inter-injection cooldown.
module xinj_sched #(
    parameter int unsigned         N      = 8,
    parameter int unsigned         LFSR_W = 16,
    parameter logic [LFSR_W-1:0]   SEED   = LFSR_W'(16'hACE1),
    parameter int unsigned         COOL   = 4,
    parameter int unsigned         CNT_W  = 16,
    parameter int unsigned         TGT_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [TGT_W-1:0] target,
    input  logic [7:0]       prob,
    input  logic [N-1:0]     mask,
    input  logic [CNT_W-1:0] budget,
    input  logic [N-1:0]     V,
    output logic [N-1:0]     rD,
    output logic [N-1:0]     rV,
    output logic             inj,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned       CW       = (COOL > 0) ? $clog2(COOL + 1) : 1;
    localparam logic [LFSR_W-1:0] POLY     = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CW-1:0]     COOL_LD  = CW'(COOL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_COOL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  budget_q, budget_d;
    logic [CW-1:0]     cool_q, cool_d;

    logic [7:0]        top_byte;
    logic [7:0]        pick;
    logic [N-1:0]      rv_raw;
    logic [CNT_W-1:0]  count_inc;
    logic              hit_budget;

    assign top_byte = lfsr_q[LFSR_W-1 -: 8];
    assign pick     = lfsr_q[7:0] % 8'(N);

    // Violation-accept pattern depends only on registered state and campaign settings.
    always_comb begin
        rv_raw = '0;
        if (state_q == S_RUN) begin
            case (mode)
                2'd1: begin
                    if (top_byte < prob) begin
                        rv_raw = N'(1) << pick;
                    end
                end
                2'd2:    rv_raw = N'(1) << target;
                2'd3:    rv_raw = '1;
                default: rv_raw = '0;
            endcase
        end
    end

    assign rV  = rv_raw & mask;
    assign inj = |(rV & V);

    assign count_inc  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    assign hit_budget = (budget_q != '0) && ((count_q + CNT_W'(1)) == budget_q);

    // Next-state: stop beats start; budget is only sampled when a campaign begins.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        budget_d = budget_q;
        cool_d   = cool_q;

        if (state_q == S_RUN || state_q == S_COOL) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        end

        if (stop) begin
            state_d = S_IDLE;
        end else if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            state_d  = S_RUN;
            count_d  = '0;
            budget_d = budget;
        end else if (state_q == S_RUN && inj) begin
            count_d = count_inc;
            if (hit_budget) begin
                state_d = S_DONE;
            end else if (COOL > 0) begin
                state_d = S_COOL;
                cool_d  = COOL_LD;
            end
        end else if (state_q == S_COOL) begin
            if (cool_q <= CW'(1)) begin
                state_d = S_RUN;
            end else begin
                cool_d = cool_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RS) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED_EFF;
            count_q  <= '0;
            budget_q <= '0;
            cool_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            budget_q <= budget_d;
            cool_q   <= cool_d;
        end
    end

    assign rD    = lfsr_q[N-1:0];
    assign count = count_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_COOL);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_xinj_sched.sv
// Self-checking bench for xinj_sched: directed scenarios plus random campaigns,
// compared each cycle against a behavioural model of the scheduler.
module tb_xinj_sched;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam int COOL  = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_COOL = 2;
    localparam int M_DONE = 3;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic             RS;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [2:0]       target;
    logic [7:0]       prob;
    logic [N-1:0]     mask;
    logic [CNT_W-1:0] budget;
    logic [N-1:0]     V;

    logic [N-1:0]     rD, rV, rD0, rV0;
    logic             inj, busy, done, inj0, busy0, done0;
    logic [CNT_W-1:0] count, count0;

    xinj_sched u_dut (
        .CK(CK), .RS(RS), .start(start), .stop(stop), .mode(mode), .target(target),
        .prob(prob), .mask(mask), .budget(budget), .V(V),
        .rD(rD), .rV(rV), .inj(inj), .count(count), .busy(busy), .done(done)
    );

    xinj_sched #(.SEED(16'h0000)) u_dut0 (
        .CK(CK), .RS(RS), .start(start), .stop(stop), .mode(mode), .target(target),
        .prob(prob), .mask(mask), .budget(budget), .V(V),
        .rD(rD0), .rV(rV0), .inj(inj0), .count(count0), .busy(busy0), .done(done0)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    int          m_state;
    logic [15:0] m_lfsr;
    int          m_count;
    int          m_budget;
    int          m_cool;

    int obs_rd, obs_rv, obs_inj, obs_count, obs_busy, obs_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rv();
        int r;
        r = 0;
        if (m_state == M_RUN) begin
            if (mode == 2'd1 && int'(m_lfsr[15:8]) < int'(prob))
                r = 1 << (int'(m_lfsr[7:0]) % N);
            else if (mode == 2'd2)
                r = 1 << int'(target);
            else if (mode == 2'd3)
                r = 255;
        end
        return r & int'(mask);
    endfunction

    task automatic model_next(input bit einj);
        bit hit;
        if (RS) begin
            m_state = M_IDLE;
            m_lfsr  = 16'hACE1;
            m_count = 0;
        end else begin
            if (m_state == M_RUN || m_state == M_COOL)
                m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            if (stop) begin
                m_state = M_IDLE;
            end else if ((m_state == M_IDLE || m_state == M_DONE) && start) begin
                m_state  = M_RUN;
                m_count  = 0;
                m_budget = int'(budget);
            end else if (m_state == M_RUN && einj) begin
                hit = (m_budget != 0) && (m_count + 1 == m_budget);
                if (m_count < 65535) m_count = m_count + 1;
                if (hit) m_state = M_DONE;
                else if (COOL > 0) begin
                    m_state = M_COOL;
                    m_cool  = COOL;
                end
            end else if (m_state == M_COOL) begin
                if (m_cool == 1) m_state = M_RUN;
                else m_cool = m_cool - 1;
            end
        end
    endtask

    // One clock cycle: inputs already set after a negedge; compare, advance model, advance clock.
    task automatic step();
        int  erv;
        bit  einj;
        #1;
        erv  = model_rv();
        einj = ((erv & int'(V)) != 0);
        chk("rD", int'(rD), int'(m_lfsr[7:0]));
        chk("rV", int'(rV), erv);
        chk("inj", int'(inj), int'(einj));
        chk("count", int'(count), m_count);
        chk("busy", int'(busy), int'(m_state == M_RUN || m_state == M_COOL));
        chk("done", int'(done), int'(m_state == M_DONE));
        obs_rd    = int'(rD);
        obs_rv    = int'(rV);
        obs_inj   = int'(inj);
        obs_count = int'(count);
        obs_busy  = int'(busy);
        obs_done  = int'(done);
        model_next(einj);
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int inj_mask, first_done, held, bad, nz, inj_seen;
        RS = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; target = 3'd0;
        prob = 8'd0; mask = 8'hFF; budget = '0; V = '0;
        m_budget = 0; m_cool = 0;
        @(posedge CK);
        @(posedge CK);
        @(negedge CK);
        m_state = M_IDLE; m_lfsr = 16'hACE1; m_count = 0;
        RS = 1'b0;
        #1;
        chk("reset_rD", int'(rD), 32'hE1);
        chk("reset_seed0_rD", int'(rD0), 1);
        chk("reset_busy", int'(busy), 0);

        // 1: all-at-once, budget 3, cooldown 4
        mode = 2'd3; mask = 8'hFF; budget = 16'd3; V = 8'h01;
        pulse_start();
        inj_mask = 0; first_done = -1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (obs_inj != 0) inj_mask |= (1 << k);
            if (obs_done != 0 && first_done < 0) first_done = k;
        end
        chk("t1_inj_cycles", inj_mask, 32'h842);
        chk("t1_done_cycle", first_done, 12);
        chk("t1_count", obs_count, 3);
        chk("t1_rv_after", obs_rv, 0);

        // 2: single target
        mode = 2'd2; target = 3'd5; V = 8'hFF; budget = 16'd0;
        pulse_start();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) chk("t2_rv_first", obs_rv, 32'h20);
            if (k == 2) chk("t2_rv_cool", obs_rv, 0);
        end
        chk("t2_count", obs_count, 4);

        // 3: random mode with prob 0, then 255
        pulse_stop();
        mode = 2'd1; prob = 8'd0; V = 8'hFF;
        pulse_start();
        nz = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (obs_rv != 0) nz++;
        end
        chk("t3_prob0_rv", nz, 0);
        prob = 8'd255; V = 8'h00;
        bad = 0; nz = 0;
        for (int k = 0; k < 200; k++) begin
            logic [7:0] top;
            top = m_lfsr[15:8];
            step();
            if (top != 8'hFF && $countones(obs_rv[7:0]) != 1) bad++;
            if (obs_rv != 0) nz++;
        end
        chk("t3_prob255_onehot", bad, 0);
        chk("t3_prob255_active", int'(nz > 150), 1);

        // 4: stop and start in the same cycle
        pulse_stop();
        mode = 2'd3; V = 8'h01; budget = 16'd10;
        pulse_start();
        for (int k = 1; k <= 7; k++) step();
        held = obs_count;
        chk("t4_count_before", held, 2);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        chk("t4_rv_idle", obs_rv, 0);
        chk("t4_busy_idle", obs_busy, 0);
        chk("t4_count_held", obs_count, 2);
        pulse_start();
        step();
        chk("t4_count_cleared", obs_count, 0);

        // 5: reset in cooldown with count 2
        for (int k = 2; k <= 7; k++) step();
        chk("t5_count_in_cool", obs_count, 2);
        chk("t5_busy_in_cool", obs_busy, 1);
        RS = 1'b1;
        step();
        RS = 1'b0;
        step();
        chk("t5_count_reset", obs_count, 0);
        chk("t5_rd_seed", obs_rd, 32'hE1);
        chk("t5_busy_reset", obs_busy, 0);
        chk("t5_seed0_rd", int'(rD0), 1);

        // 6: masked off, long LFSR run
        mask = 8'h00; mode = 2'd3; V = 8'hFF; budget = 16'd0;
        pulse_start();
        inj_seen = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (k == 1) chk("t6_rd_k1", obs_rd, 32'hE1);
            if (k == 2) chk("t6_rd_k2", obs_rd, 32'h70);
            inj_seen += obs_inj;
        end
        chk("t6_inj_none", inj_seen, 0);
        chk("t6_count", obs_count, 0);

        // Random campaigns
        for (int k = 0; k < 4000; k++) begin
            RS     = ($urandom_range(0, 299) == 0);
            stop   = ($urandom_range(0, 59) == 0);
            start  = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 19) == 0) begin
                mode   = 2'($urandom_range(0, 3));
                target = 3'($urandom_range(0, 7));
                prob   = 8'($urandom);
                mask   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            end
            budget = 16'($urandom_range(0, 6));
            V      = 8'($urandom);
            step();
        end
        RS = 1'b0; stop = 1'b0; start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
